ctrl_pipe_regs: RTL and testbench

Control-side pipeline register chain for the 5-stage MIPS CPU. It carries the fetched instruction into ID, then carries the decoded control bundle through EXE, MEM and WB. Each stage obeys the per-stage `rst`/`en` pair issued by the pipeline controller, and the block returns the stage valid flags and hazard feedback signals (`is_branch_*`, `regw_addr_*`, `wb_wen_*`, `is_load_exe`) that the controller uses. It is the responder end of the controller's stage-control interface.

---
 rtl/ctrl_pipe_regs_pkg.sv | 82 ++++++++
 rtl/ctrl_pipe_regs_stage.sv | 25 ++
 rtl/ctrl_pipe_regs.sv | 148 ++++++++++++++
 tb/tb_ctrl_pipe_regs.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared encodings and stage-register layouts for the control pipeline register chain.
// The PC-source, write-back address and ALU encodings live only here.
package ctrl_pipe_regs_pkg;

  typedef enum logic [2:0] {
    PC_NEXT = 3'd0,
    PC_JUMP = 3'd1,
    PC_JR   = 3'd2,
    PC_BEQ  = 3'd3,
    PC_BNE  = 3'd4
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ADDR_RD   = 2'd0,
    WB_ADDR_RT   = 2'd1,
    WB_ADDR_LINK = 2'd2
  } wb_addr_src_e;

  typedef enum logic [3:0] {
    EXE_ALU_NONE = 4'd0,
    EXE_ALU_ADD  = 4'd1,
    EXE_ALU_SUB  = 4'd2,
    EXE_ALU_AND  = 4'd3,
    EXE_ALU_OR   = 4'd4,
    EXE_ALU_XOR  = 4'd5,
    EXE_ALU_NOR  = 4'd6,
    EXE_ALU_SLT  = 4'd7,
    EXE_ALU_SLL  = 4'd8,
    EXE_ALU_SRL  = 4'd9,
    EXE_ALU_SRA  = 4'd10,
    EXE_ALU_LUI  = 4'd11
  } exe_alu_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
  } id_stage_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_oper;
    logic       mem_ren;
    logic       mem_wen;
    logic       wb_data_src;
    logic       wb_wen;
    logic       is_branch;
    logic       is_load;
    logic [4:0] regw_addr;
  } exe_stage_t;

  typedef struct packed {
    logic       valid;
    logic       mem_ren;
    logic       mem_wen;
    logic       wb_data_src;
    logic       wb_wen;
    logic       is_branch;
    logic [4:0] regw_addr;
  } mem_stage_t;

  typedef struct packed {
    logic       valid;
    logic       wb_data_src;
    logic       wb_wen;
    logic [4:0] regw_addr;
  } wb_stage_t;

  // Destination register selected by the decoder's write-back address source.
  function automatic logic [4:0] resolveRegwAddr(input logic [4:0] rd, input logic [4:0] rt,
                                                 input logic [1:0] src);
    logic [4:0] addr;
    addr = 5'd0;
    case (src)
      WB_ADDR_RD:   addr = rd;
      WB_ADDR_RT:   addr = rt;
      WB_ADDR_LINK: addr = 5'd31;
      default:      addr = 5'd0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/ctrl_pipe_regs_stage.sv
// One pipeline stage register: clear on reset, load when enabled, otherwise hold.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Control-side register chain IF->ID->EXE->MEM->WB with valid-gated hazard feedback
// and a retired-instruction counter.
module ctrl_pipe_regs
  import ctrl_pipe_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_rst,
  input  logic             if_en,
  input  logic             id_rst,
  input  logic             id_en,
  input  logic             exe_rst,
  input  logic             exe_en,
  input  logic             mem_rst,
  input  logic             mem_en,
  input  logic             wb_rst,
  input  logic             wb_en,
  input  logic [31:0]      inst_if,
  input  logic [2:0]       pc_src_id,
  input  logic [3:0]       exe_alu_oper_id,
  input  logic             mem_ren_id,
  input  logic             mem_wen_id,
  input  logic [1:0]       wb_addr_src_id,
  input  logic             wb_data_src_id,
  input  logic             wb_wen_id,
  output logic             if_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [31:0]      inst_id,
  output logic [3:0]       exe_alu_oper_exe,
  output logic             is_branch_exe,
  output logic             is_load_exe,
  output logic             wb_wen_exe,
  output logic [4:0]       regw_addr_exe,
  output logic             mem_ren_mem,
  output logic             mem_wen_mem,
  output logic             is_branch_mem,
  output logic             wb_wen_mem,
  output logic [4:0]       regw_addr_mem,
  output logic             wb_data_src_wb,
  output logic             wb_wen_wb,
  output logic [4:0]       regw_addr_wb,
  output logic [CNT_W-1:0] retired
);

  logic             r_if_valid;
  logic [CNT_W-1:0] r_retired;
  id_stage_t        w_id_d,  w_id_q;
  exe_stage_t       w_exe_d, w_exe_q;
  mem_stage_t       w_mem_d, w_mem_q;
  wb_stage_t        w_wb_d,  w_wb_q;

  // IF has no upstream valid: an enabled fetch slot is always occupied.
  always_ff @(posedge clk) begin
    if (rst || if_rst) begin
      r_if_valid <= 1'b0;
    end else if (if_en) begin
      r_if_valid <= 1'b1;
    end
  end

  always_comb begin
    w_id_d       = '0;
    w_id_d.valid = r_if_valid;
    w_id_d.inst  = inst_if;

    w_exe_d             = '0;
    w_exe_d.valid       = w_id_q.valid;
    w_exe_d.alu_oper    = exe_alu_oper_id;
    w_exe_d.mem_ren     = mem_ren_id;
    w_exe_d.mem_wen     = mem_wen_id;
    w_exe_d.wb_data_src = wb_data_src_id;
    w_exe_d.wb_wen      = wb_wen_id;
    w_exe_d.is_branch   = (pc_src_id != PC_NEXT);
    w_exe_d.is_load     = mem_ren_id;
    w_exe_d.regw_addr   = resolveRegwAddr(w_id_q.inst[15:11], w_id_q.inst[20:16], wb_addr_src_id);

    w_mem_d             = '0;
    w_mem_d.valid       = w_exe_q.valid;
    w_mem_d.mem_ren     = w_exe_q.mem_ren;
    w_mem_d.mem_wen     = w_exe_q.mem_wen;
    w_mem_d.wb_data_src = w_exe_q.wb_data_src;
    w_mem_d.wb_wen      = w_exe_q.wb_wen;
    w_mem_d.is_branch   = w_exe_q.is_branch;
    w_mem_d.regw_addr   = w_exe_q.regw_addr;

    w_wb_d             = '0;
    w_wb_d.valid       = w_mem_q.valid;
    w_wb_d.wb_data_src = w_mem_q.wb_data_src;
    w_wb_d.wb_wen      = w_mem_q.wb_wen;
    w_wb_d.regw_addr   = w_mem_q.regw_addr;
  end

  pipe_stage_reg #(.W($bits(id_stage_t))) u_id_reg (
    .clk(clk), .rst(rst), .i_clr(id_rst), .i_en(id_en), .i_d(w_id_d), .o_q(w_id_q)
  );

  pipe_stage_reg #(.W($bits(exe_stage_t))) u_exe_reg (
    .clk(clk), .rst(rst), .i_clr(exe_rst), .i_en(exe_en), .i_d(w_exe_d), .o_q(w_exe_q)
  );

  pipe_stage_reg #(.W($bits(mem_stage_t))) u_mem_reg (
    .clk(clk), .rst(rst), .i_clr(mem_rst), .i_en(mem_en), .i_d(w_mem_d), .o_q(w_mem_q)
  );

  pipe_stage_reg #(.W($bits(wb_stage_t))) u_wb_reg (
    .clk(clk), .rst(rst), .i_clr(wb_rst), .i_en(wb_en), .i_d(w_wb_d), .o_q(w_wb_q)
  );

  // An instruction retires when a valid WB slot is displaced by an enabled, unreset load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_wb_q.valid && wb_en && !wb_rst) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign if_valid  = r_if_valid;
  assign id_valid  = w_id_q.valid;
  assign exe_valid = w_exe_q.valid;
  assign mem_valid = w_mem_q.valid;
  assign wb_valid  = w_wb_q.valid;
  assign inst_id   = w_id_q.inst;
  assign retired   = r_retired;

  // Bubbles must never write, read, stall or name a destination register.
  assign exe_alu_oper_exe = w_exe_q.valid ? w_exe_q.alu_oper : 4'd0;
  assign is_branch_exe    = w_exe_q.valid & w_exe_q.is_branch;
  assign is_load_exe      = w_exe_q.valid & w_exe_q.is_load;
  assign wb_wen_exe       = w_exe_q.valid & w_exe_q.wb_wen;
  assign regw_addr_exe    = w_exe_q.valid ? w_exe_q.regw_addr : 5'd0;

  assign mem_ren_mem   = w_mem_q.valid & w_mem_q.mem_ren;
  assign mem_wen_mem   = w_mem_q.valid & w_mem_q.mem_wen;
  assign is_branch_mem = w_mem_q.valid & w_mem_q.is_branch;
  assign wb_wen_mem    = w_mem_q.valid & w_mem_q.wb_wen;
  assign regw_addr_mem = w_mem_q.valid ? w_mem_q.regw_addr : 5'd0;

  assign wb_data_src_wb = w_wb_q.wb_data_src;
  assign wb_wen_wb      = w_wb_q.valid & w_wb_q.wb_wen;
  assign regw_addr_wb   = w_wb_q.valid ? w_wb_q.regw_addr : 5'd0;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed, table-driven bench for ctrl_pipe_regs with a narrow counter so wrap is reachable.
module tb_ctrl_pipe_regs;
  import ctrl_pipe_regs_pkg::*;

  localparam int CNT_W = 3;
  localparam logic [31:0] INST_ADD = 32'h0022_1820;
  localparam logic [31:0] INST_LW  = 32'h8C25_0000;
  localparam logic [31:0] INST_JAL = 32'h0C00_0010;

  typedef struct packed {
    logic [2:0] pc;
    logic [3:0] alu;
    logic       ren;
    logic       wen;
    logic [1:0] addrSrc;
    logic       dataSrc;
    logic       wbWen;
  } ctl_t;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rsts;
    logic [4:0]  ens;
    logic [31:0] instIf;
    ctl_t        ctl;
  } stim_t;

  // flags = {wb_wen_exe, is_load_exe, is_branch_exe, mem_ren_mem, mem_wen_mem,
  //          is_branch_mem, wb_wen_mem, wb_wen_wb, wb_data_src_wb}
  typedef struct packed {
    logic [4:0]       valids;
    logic [31:0]      inst;
    logic [4:0]       regwExe;
    logic [4:0]       regwMem;
    logic [4:0]       regwWb;
    logic [3:0]       alu;
    logic [8:0]       flags;
    logic [CNT_W-1:0] retired;
  } obs_t;

  typedef struct packed {
    stim_t stim;
    obs_t  exp;
  } vec_t;

  logic clk, rst;
  logic if_rst, if_en, id_rst, id_en, exe_rst, exe_en, mem_rst, mem_en, wb_rst, wb_en;
  logic [31:0] inst_if;
  logic [2:0] pc_src_id;
  logic [3:0] exe_alu_oper_id;
  logic mem_ren_id, mem_wen_id, wb_data_src_id, wb_wen_id;
  logic [1:0] wb_addr_src_id;
  logic if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [31:0] inst_id;
  logic [3:0] exe_alu_oper_exe;
  logic is_branch_exe, is_load_exe, wb_wen_exe;
  logic [4:0] regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic mem_ren_mem, mem_wen_mem, is_branch_mem, wb_wen_mem;
  logic wb_data_src_wb, wb_wen_wb;
  logic [CNT_W-1:0] retired;

  int vecCount = 0;
  int missCount = 0;
  vec_t vecs[$];
  ctl_t ctlNop, ctlAdd, ctlLw, ctlJal;

  ctrl_pipe_regs #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
    .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
    .wb_rst(wb_rst), .wb_en(wb_en),
    .inst_if(inst_if), .pc_src_id(pc_src_id), .exe_alu_oper_id(exe_alu_oper_id),
    .mem_ren_id(mem_ren_id), .mem_wen_id(mem_wen_id), .wb_addr_src_id(wb_addr_src_id),
    .wb_data_src_id(wb_data_src_id), .wb_wen_id(wb_wen_id),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .inst_id(inst_id),
    .exe_alu_oper_exe(exe_alu_oper_exe), .is_branch_exe(is_branch_exe),
    .is_load_exe(is_load_exe), .wb_wen_exe(wb_wen_exe), .regw_addr_exe(regw_addr_exe),
    .mem_ren_mem(mem_ren_mem), .mem_wen_mem(mem_wen_mem), .is_branch_mem(is_branch_mem),
    .wb_wen_mem(wb_wen_mem), .regw_addr_mem(regw_addr_mem),
    .wb_data_src_wb(wb_data_src_wb), .wb_wen_wb(wb_wen_wb), .regw_addr_wb(regw_addr_wb),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkStim(input logic r, input logic [4:0] rs, input logic [4:0] en,
                                   input logic [31:0] ins, input ctl_t c);
    stim_t s;
    s.rst = r; s.rsts = rs; s.ens = en; s.instIf = ins; s.ctl = c;
    return s;
  endfunction

  function automatic obs_t mkObs(input logic [4:0] v, input logic [31:0] ins,
                                 input logic [4:0] re, input logic [4:0] rm, input logic [4:0] rw,
                                 input logic [3:0] alu, input logic [8:0] fl,
                                 input logic [CNT_W-1:0] ret);
    obs_t o;
    o.valids = v; o.inst = ins; o.regwExe = re; o.regwMem = rm; o.regwWb = rw;
    o.alu = alu; o.flags = fl; o.retired = ret;
    return o;
  endfunction

  function automatic obs_t sampleObs();
    obs_t o;
    o.valids  = {if_valid, id_valid, exe_valid, mem_valid, wb_valid};
    o.inst    = inst_id;
    o.regwExe = regw_addr_exe;
    o.regwMem = regw_addr_mem;
    o.regwWb  = regw_addr_wb;
    o.alu     = exe_alu_oper_exe;
    o.flags   = {wb_wen_exe, is_load_exe, is_branch_exe, mem_ren_mem, mem_wen_mem,
                 is_branch_mem, wb_wen_mem, wb_wen_wb, wb_data_src_wb};
    o.retired = retired;
    return o;
  endfunction

  task automatic addVec(input stim_t s, input obs_t e);
    vec_t v;
    v.stim = s; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample #1 after the active edge.
  task automatic applyStimulus(input stim_t s);
    rst = s.rst;
    {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = s.rsts;
    {if_en, id_en, exe_en, mem_en, wb_en} = s.ens;
    inst_if = s.instIf;
    pc_src_id = s.ctl.pc;
    exe_alu_oper_id = s.ctl.alu;
    mem_ren_id = s.ctl.ren;
    mem_wen_id = s.ctl.wen;
    wb_addr_src_id = s.ctl.addrSrc;
    wb_data_src_id = s.ctl.dataSrc;
    wb_wen_id = s.ctl.wbWen;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    ctlNop = '{pc: PC_NEXT, alu: EXE_ALU_NONE, ren: 1'b0, wen: 1'b0, addrSrc: WB_ADDR_RD,
               dataSrc: 1'b0, wbWen: 1'b0};
    ctlAdd = '{pc: PC_NEXT, alu: EXE_ALU_ADD, ren: 1'b0, wen: 1'b0, addrSrc: WB_ADDR_RD,
               dataSrc: 1'b0, wbWen: 1'b1};
    ctlLw  = '{pc: PC_NEXT, alu: EXE_ALU_ADD, ren: 1'b1, wen: 1'b0, addrSrc: WB_ADDR_RT,
               dataSrc: 1'b1, wbWen: 1'b1};
    ctlJal = '{pc: PC_JUMP, alu: EXE_ALU_ADD, ren: 1'b0, wen: 1'b0, addrSrc: WB_ADDR_LINK,
               dataSrc: 1'b0, wbWen: 1'b1};

    // add, lw, jal streamed through a full pipe, then id_rst bubbles with stale decode.
    addVec(mkStim(1, 5'b00000, 5'b00000, 32'h0, ctlNop), mkObs(5'b00000, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b10000, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, INST_ADD, ctlNop), mkObs(5'b11000, INST_ADD, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, INST_LW, ctlAdd), mkObs(5'b11100, INST_LW, 3, 0, 0, 1, 9'b100000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, INST_JAL, ctlLw), mkObs(5'b11110, INST_JAL, 5, 3, 0, 1, 9'b110000100, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlJal), mkObs(5'b11111, 32'h0, 31, 5, 3, 1, 9'b101100110, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11111, 32'h0, 0, 31, 5, 0, 9'b000001111, 1));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11111, 32'h0, 0, 0, 31, 0, 9'b000000010, 2));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11111, 32'h0, 0, 0, 0, 0, 9'b000000000, 3));
    addVec(mkStim(0, 5'b00000, 5'b11111, INST_JAL, ctlNop), mkObs(5'b11111, INST_JAL, 0, 0, 0, 0, 9'b000000000, 4));
    addVec(mkStim(0, 5'b01000, 5'b11111, 32'h0, ctlJal), mkObs(5'b10111, 32'h0, 31, 0, 0, 1, 9'b101000000, 5));
    addVec(mkStim(0, 5'b01000, 5'b11111, 32'h0, ctlJal), mkObs(5'b10011, 32'h0, 0, 31, 0, 0, 9'b000001100, 6));
    addVec(mkStim(0, 5'b01000, 5'b11111, 32'h0, ctlJal), mkObs(5'b10001, 32'h0, 0, 0, 31, 0, 9'b000000010, 7));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlJal), mkObs(5'b11000, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11100, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11110, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));
    addVec(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop), mkObs(5'b11111, 32'h0, 0, 0, 0, 0, 9'b000000000, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d", i), 96'(sampleObs()), 96'(vecs[i].exp));
    end

    // Reset beats enable on EXE even with a valid instruction waiting in ID.
    applyStimulus(mkStim(0, 5'b00000, 5'b11111, INST_ADD, ctlNop));
    checkOutput("loadAdd inst_id", 96'(inst_id), 96'(INST_ADD));
    applyStimulus(mkStim(0, 5'b00100, 5'b11111, 32'h0, ctlAdd));
    checkOutput("exeRstEn exe_valid", 96'(exe_valid), 96'(1'b0));
    checkOutput("exeRstEn wb_wen_exe", 96'(wb_wen_exe), 96'(1'b0));
    checkOutput("exeRstEn regw_addr_exe", 96'(regw_addr_exe), 96'(5'd0));

    // Held ID survives an EXE bubble, then stalled EXE is duplicated into MEM.
    applyStimulus(mkStim(0, 5'b00000, 5'b11111, INST_LW, ctlNop));
    checkOutput("loadLw inst_id", 96'(inst_id), 96'(INST_LW));
    applyStimulus(mkStim(0, 5'b00100, 5'b00111, INST_JAL, ctlLw));
    checkOutput("heldId inst_id", 96'(inst_id), 96'(INST_LW));
    checkOutput("heldId valids", 96'({id_valid, exe_valid}), 96'(2'b10));
    applyStimulus(mkStim(0, 5'b00000, 5'b00111, INST_JAL, ctlLw));
    checkOutput("lwExe regw/load", 96'({exe_valid, is_load_exe, regw_addr_exe}), 96'({1'b1, 1'b1, 5'd5}));
    applyStimulus(mkStim(0, 5'b00000, 5'b11011, 32'h0, ctlLw));
    checkOutput("exeStall hold", 96'({is_load_exe, regw_addr_exe}), 96'({1'b1, 5'd5}));
    checkOutput("exeStall memCopy", 96'({mem_ren_mem, regw_addr_mem}), 96'({1'b1, 5'd5}));
    applyStimulus(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop));
    checkOutput("lwLeaves is_load_exe", 96'(is_load_exe), 96'(1'b0));
    checkOutput("lwDup mem_ren_mem", 96'(mem_ren_mem), 96'(1'b1));

    // Global reset mid-operation empties everything; IF refills one cycle later.
    applyStimulus(mkStim(1, 5'b00000, 5'b11111, INST_ADD, ctlAdd));
    checkOutput("midRst state", 96'({if_valid, id_valid, exe_valid, mem_valid, wb_valid, inst_id, retired}),
                96'({5'b00000, 32'h0, 3'd0}));
    applyStimulus(mkStim(0, 5'b00000, 5'b11111, 32'h0, ctlNop));
    checkOutput("refill valids", 96'({if_valid, id_valid, exe_valid, mem_valid, wb_valid}), 96'(5'b10000));
    applyStimulus(mkStim(0, 5'b10000, 5'b11111, 32'h0, ctlNop));
    checkOutput("ifRstWins valids", 96'({if_valid, id_valid, exe_valid, mem_valid, wb_valid}), 96'(5'b01000));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
